// File: rtl/mem_pkg.sv
// Shared types and default widths for the multi-cycle data memory responder.
package mem_pkg;

    localparam int unsigned WORD_LEN     = 8;
    localparam int unsigned MEM_ADDR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the responder (slave).
interface data_mem_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LEN,
    parameter int unsigned ADDR_LENGTH = MEM_ADDR_LEN
);

    logic                   req_valid;
    logic                   req_write;
    logic [ADDR_LENGTH-1:0] req_addr;
    logic [WORD_LENGTH-1:0] req_wdata;
    logic                   stall;
    logic                   busy;
    logic                   resp_valid;
    logic [WORD_LENGTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  stall, busy, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output stall, busy, resp_valid, resp_rdata
    );

endinterface

// File: rtl/data_mem_array.sv
// DEPTH x WORD_LENGTH storage: async active-low clear, synchronous write, combinational read.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LEN,
    parameter int unsigned ADDR_LENGTH = MEM_ADDR_LEN,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    input  logic [WORD_LENGTH-1:0] i_wdata,
    output logic [WORD_LENGTH-1:0] o_rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_LENGTH-1:0] r_mem [DEPTH];
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_idx;

    // Addresses beyond DEPTH neither write nor read anything real.
    assign w_in_range = (32'(i_addr) < DEPTH);
    assign w_idx      = i_addr[IDX_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage responder: captures one load/store, waits LATENCY cycles, then
// accesses the array and pulses resp_valid, stalling the pipeline until the DONE cycle.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WORD_LEN,
    parameter int unsigned ADDR_LENGTH = MEM_ADDR_LEN,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_write;
    logic [ADDR_LENGTH-1:0] r_addr;
    logic [WORD_LENGTH-1:0] r_wdata;
    logic                   r_resp_valid;
    logic [WORD_LENGTH-1:0] r_resp_rdata;

    logic                   w_access;
    logic                   w_we;
    logic [WORD_LENGTH-1:0] w_rdata;

    // The array only ever sees the captured request, never the live bus fields.
    assign w_access = (r_state == WAIT) && (r_cnt == '0);
    assign w_we     = w_access && r_write;

    data_mem_array #(
        .WORD_LENGTH (WORD_LENGTH),
        .ADDR_LENGTH (ADDR_LENGTH),
        .DEPTH       (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        // Stores leave the last load result untouched.
                        if (!r_write) begin
                            r_resp_rdata <= w_rdata;
                        end
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances on the response cycle.
    assign bus.stall      = bus.req_valid && (r_state != DONE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2/DEPTH=256 instance and a LATENCY=1/DEPTH=16
// instance, checked cycle by cycle against an array-based reference model.
module tb_data_mem_responder;

    localparam int WL = 8;
    localparam int AL = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       rv  [2];
    logic       rw  [2];
    logic [7:0] ra  [2];
    logic [7:0] rwd [2];
    logic       st  [2];
    logic       bz  [2];
    logic       vv  [2];
    logic [7:0] rd  [2];

    data_mem_responder_if #(.WORD_LENGTH(WL), .ADDR_LENGTH(AL)) bus_a ();
    data_mem_responder_if #(.WORD_LENGTH(WL), .ADDR_LENGTH(AL)) bus_b ();

    assign bus_a.req_valid = rv[0];
    assign bus_a.req_write = rw[0];
    assign bus_a.req_addr  = ra[0];
    assign bus_a.req_wdata = rwd[0];
    assign st[0] = bus_a.stall;
    assign bz[0] = bus_a.busy;
    assign vv[0] = bus_a.resp_valid;
    assign rd[0] = bus_a.resp_rdata;

    assign bus_b.req_valid = rv[1];
    assign bus_b.req_write = rw[1];
    assign bus_b.req_addr  = ra[1];
    assign bus_b.req_wdata = rwd[1];
    assign st[1] = bus_b.stall;
    assign bz[1] = bus_b.busy;
    assign vv[1] = bus_b.resp_valid;
    assign rd[1] = bus_b.resp_rdata;

    data_mem_responder #(
        .WORD_LENGTH (WL),
        .ADDR_LENGTH (AL),
        .DEPTH       (256),
        .LATENCY     (2)
    ) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a.slave)
    );

    data_mem_responder #(
        .WORD_LENGTH (WL),
        .ADDR_LENGTH (AL),
        .DEPTH       (16),
        .LATENCY     (1)
    ) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mdl [2][256];
    logic [7:0] last_rd [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mdl[d][i] = 8'h00;
            last_rd[d] = 8'h00;
        end
    endtask

    // One complete operation starting in an IDLE cycle; response expected LATENCY+1 later.
    task automatic op(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      input bit drop, input bit chain);
        int         done_c;
        logic [7:0] exp_rd;
        logic       exp_st;
        logic [7:0] exp_hold;
        done_c = lat_of(d) + 1;
        if (wr) exp_rd = last_rd[d];
        else    exp_rd = (int'(addr) < depth_of(d)) ? mdl[d][addr] : 8'h00;
        rv[d] = 1'b1; rw[d] = wr; ra[d] = addr; rwd[d] = wd;
        for (int c = 0; c <= done_c; c++) begin
            if (c == 1 && drop) rv[d] = 1'b0;
            if (c >= 1) begin
                ra[d]  = 8'($urandom);
                rwd[d] = 8'($urandom);
                rw[d]  = 1'($urandom);
            end
            @(negedge clk);
            exp_st   = rv[d] && (c != done_c);
            exp_hold = (c == done_c) ? exp_rd : last_rd[d];
            n_checks++;
            if (st[d] !== exp_st)
                $display("FAIL stall dut%0d cyc%0d: got %b, expected %b", d, c, st[d], exp_st);
            else n_pass++;
            n_checks++;
            if (vv[d] !== (c == done_c))
                $display("FAIL resp_valid dut%0d cyc%0d: got %b, expected %b", d, c, vv[d],
                         (c == done_c));
            else n_pass++;
            n_checks++;
            if (bz[d] !== (c != 0))
                $display("FAIL busy dut%0d cyc%0d: got %b, expected %b", d, c, bz[d], (c != 0));
            else n_pass++;
            n_checks++;
            if (rd[d] !== exp_hold)
                $display("FAIL resp_rdata dut%0d cyc%0d addr %0h: got %0h, expected %0h",
                         d, c, addr, rd[d], exp_hold);
            else n_pass++;
            @(posedge clk); #1;
        end
        if (wr && int'(addr) < depth_of(d)) mdl[d][addr] = wd;
        if (!wr) last_rd[d] = exp_rd;
        if (!chain) begin
            rv[d] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bz[d] !== 1'b0 || vv[d] !== 1'b0)
                $display("FAIL idle_after dut%0d: got busy %b valid %b, expected 0 0",
                         d, bz[d], vv[d]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b1; rw[d] = 1'b1; ra[d] = 8'h44; rwd[d] = 8'h99;
        end
        #2 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (st[d] !== 1'b1 || bz[d] !== 1'b0 || vv[d] !== 1'b0 || rd[d] !== 8'h00)
                    $display("FAIL reset dut%0d: got stall %b busy %b valid %b rdata %0h, expected 1 0 0 0",
                             d, st[d], bz[d], vv[d], rd[d]);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv[0] = 1'b0; rv[1] = 1'b0;
        clear_model();
        op(0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_store_load();
        op(0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
        op(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_hold_rdata();
        op(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        op(0, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0);
        n_checks++;
        if (rd[0] !== 8'hA5)
            $display("FAIL hold_rdata: got %0h, expected a5", rd[0]);
        else n_pass++;
    endtask

    task automatic test_flush();
        op(0, 1'b1, 8'h05, 8'h3C, 1'b1, 1'b0);
        op(0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        op(0, 1'b1, 8'h30, 8'h5E, 1'b0, 1'b1);
        op(0, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
        op(0, 1'b1, 8'h31, 8'h22, 1'b0, 1'b1);
        op(0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midop();
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 8'h08; rwd[0] = 8'h77;
        @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (bz[0] !== 1'b1)
            $display("FAIL midop_busy_before: got %b, expected 1", bz[0]);
        else n_pass++;
        rst_n = 1'b0;
        rv[0] = 1'b0;
        #1;
        n_checks++;
        if (bz[0] !== 1'b0 || vv[0] !== 1'b0)
            $display("FAIL midop_reset: got busy %b valid %b, expected 0 0", bz[0], vv[0]);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (vv[0] !== 1'b0 || bz[0] !== 1'b0)
                $display("FAIL midop_no_pulse cyc%0d: got valid %b busy %b, expected 0 0",
                         k, vv[0], bz[0]);
            else n_pass++;
            @(posedge clk); #1;
        end
        op(0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_lat1_depth16();
        op(1, 1'b1, 8'h03, 8'hC7, 1'b0, 1'b0);
        op(1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0);
        op(1, 1'b1, 8'h20, 8'h5A, 1'b0, 1'b0);
        op(1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
        op(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                if (d == 1)               a = 8'($urandom_range(0, 31));
                else if ($urandom % 2 == 1) a = 8'($urandom_range(0, 15));
                else                      a = 8'($urandom);
                op(d, 1'($urandom), a, 8'($urandom), ($urandom_range(0, 3) == 0),
                   (i < 29) && ($urandom_range(0, 1) == 1));
            end
        end
    endtask

    initial begin
        rv[0] = 1'b0; rv[1] = 1'b0;
        rw[0] = 1'b0; rw[1] = 1'b0;
        ra[0] = 8'h00; ra[1] = 8'h00;
        rwd[0] = 8'h00; rwd[1] = 8'h00;
        clear_model();
        test_reset();
        test_store_load();
        test_hold_rdata();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        test_lat1_depth16();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the datapath's MEM-stage load/store requests. It replaces the zero-wait data memory with a multi-cycle backing store. It accepts one read or write per handshake, takes a parameterised number of cycles, and drives a stall back to the pipeline until the response cycle. It sits between the EX/MEM pipeline register (address = ALU result, write data = forwarded reg2) and the MEM/WB register.

Parameters:
WORD_LENGTH, 8, data word width
ADDR_LENGTH, 8, address width
DEPTH, 256, number of stored words (<= 2**ADDR_LENGTH)
LATENCY, 2, wait cycles between accept and array access (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  MEM stage presents a memory operation
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_LENGTH  word address
req_wdata  input  WORD_LENGTH  store data
stall  output  1  freeze PC/PR1/PR2/PR3; hold request stable
busy  output  1  FSM not in IDLE
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  WORD_LENGTH  load result; held until next load completes

Behaviour:
- Reset (rst=0, async): FSM to IDLE; counter 0; captured request cleared; resp_valid=0; resp_rdata=0; all DEPTH words cleared to 0. Any in-flight write is discarded.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if req_valid=1, capture req_write/req_addr/req_wdata, load counter with LATENCY-1, go to WAIT. Otherwise stay in IDLE.
- WAIT: counter decrements each cycle. In the cycle counter==0 the array is accessed:
  - store writes the captured data;
  - load registers array[addr] into resp_rdata.
  Next state is DONE.
- DONE: resp_valid=1 for exactly this cycle. Next state is always IDLE; a new request is sampled there.
- Latency: accept in cycle N, response at cycle N+LATENCY+1. Throughput is one op per LATENCY+2 cycles.
- stall = req_valid & (state != DONE), combinational. The pipeline advances in the DONE cycle.
- Requester holds request fields stable while stall=1. The responder uses only the captured copy, so later changes are ignored.
- req_valid dropped mid-operation (pipeline flush): the operation still completes. A store is committed, resp_valid still pulses, and stall follows req_valid low.
- Address >= DEPTH: store ignored; load returns 0.
- Loads after stores to the same address are serialised, so there is no hazard and no forwarding.
- resp_rdata is unchanged by store completions.
- busy = (state != IDLE).
- Counter width: $clog2(LATENCY+1). LATENCY=1 gives exactly one WAIT cycle.

Decomposition:
- Shared package mem_pkg:
  - typedef enum mem_state_t {IDLE, WAIT, DONE};
  - default width constants WORD_LEN=8, MEM_ADDR_LEN=8.
- Sub-module data_mem_array: DEPTH x WORD_LENGTH storage with async active-low clear, synchronous write enable, combinational read. The responder owns the FSM, counter, capture registers and stall logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> stall=1 combinationally, busy=0, resp_valid=0, resp_rdata=0x00. After release, a load from 0xFF returns 0x00.
- Store then load, LATENCY=2:
  - store 0xA5 to 0x10 accepted at cycle 0 -> stall=1 cycles 0-2, resp_valid=1 and stall=0 at cycle 3, busy=0 at cycle 4;
  - then load 0x10 -> resp_rdata=0xA5 with resp_valid three cycles after accept.
- Flush mid-op: store 0x3C to 0x05, drop req_valid at cycle 1 -> stall=0 from cycle 1, resp_valid pulses at cycle 3; a later load of 0x05 returns 0x3C.
- Reset mid-op: store 0x77 to 0x08, assert rst at cycle 1 -> busy=0 immediately, no resp_valid pulse; a later load of 0x08 returns 0x00.
- Hold rdata: load 0x10 (=0xA5), then store 0x11 to 0x20 -> resp_rdata stays 0xA5 through the store's DONE cycle. Back-to-back requests are accepted only in IDLE, one cycle after DONE.
- LATENCY=1 instance: load accepted at cycle 0 -> stall=1 cycles 0-1, resp_valid at cycle 2. DEPTH=16 instance: store to 0x20 is ignored and a load from 0x20 returns 0x00.
